multisim_pull_arbiter: RTL

MULTISIM_PULL_ARBITER -- requirements
Module: multisim_pull_arbiter

---
 rtl/multisim_pull_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multisim_pull_arbiter.sv
// -----------------------------------------------------------------------------
// multisim_pull_arbiter
//
// Round-robin arbiter that connects one upstream pull server to N_REQ
// downstream requesters over a shared data bus. A single requester owns
// the bus at a time, for up to MAX_BURST transfers.
//
// The grant ends when its burst completes or when the grantee drops its
// request. Every release is followed by exactly one IDLE cycle before the
// next grant. A word that is valid but has not been accepted when the grant
// ends stays with the upstream and goes to the next grantee. No word is
// lost or delivered twice.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   up_data_vld/up_data  word offered by the pull server
//   up_data_rdy          ready to the pull server (dn_data_rdy of the grantee)
//   req[N_REQ]           level-sensitive requests
//   gnt[N_REQ]           registered one-hot grant
//   dn_data_vld[N_REQ]   per-requester valid (only the grantee sees vld)
//   dn_data              shared data bus (= up_data)
//   dn_data_rdy[N_REQ]   per-requester ready
//   busy                 high while a grant is held
//   xfer_cnt             (MULTISIM_PULL_ARBITER_STATS_EN only) 32-bit
//                        transfer counter per requester, slice [32*i +: 32]
//
// Optional feature macro: MULTISIM_PULL_ARBITER_STATS_EN
// -----------------------------------------------------------------------------
module multisim_pull_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_data_vld,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  up_data_rdy,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      dn_data_vld,
  output logic [DATA_WIDTH-1:0] dn_data,
  input  logic [N_REQ-1:0]      dn_data_rdy,
  output logic                  busy
`ifdef MULTISIM_PULL_ARBITER_STATS_EN
  ,
  output logic [N_REQ*32-1:0]   xfer_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [7:0]       burst_cnt;

  // Round-robin pick: scan offsets 1..N_REQ from last_idx. The first set
  // bit found wins. Offset N_REQ wraps back to last_idx itself, so the
  // previous winner is chosen again only when nobody else is requesting.
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;

  always_comb begin
    found   = 1'b0;
    win_idx = last_idx;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (IDX_W+1)'((int'(last_idx) + k) % N_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // gnt is zero outside GRANT. Because of that, the data-path muxes below
  // need no separate state qualification.
  assign busy        = (state == GRANT);
  assign dn_data     = up_data;
  assign dn_data_vld = gnt & {N_REQ{up_data_vld}};
  assign up_data_rdy = |(gnt & dn_data_rdy);

  logic xfer, req_g, burst_done, rel;

  assign xfer       = busy & up_data_vld & up_data_rdy;
  assign req_g      = |(req & gnt);
  assign burst_done = xfer && (burst_cnt == 8'(MAX_BURST - 1));
  // Burst end and request drop on the same cycle collapse into one release.
  assign rel        = busy && (burst_done || !req_g);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      burst_cnt <= '0;
      last_idx  <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (found) begin
            gnt      <= N_REQ'(1) << win_idx;
            last_idx <= win_idx;
            state    <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state     <= IDLE;
            gnt       <= '0;
            burst_cnt <= '0;
          end else if (xfer) begin
            // This branch is never reached with burst_cnt at MAX_BURST-1,
            // so the 8-bit counter cannot wrap within a grant.
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

`ifdef MULTISIM_PULL_ARBITER_STATS_EN
  logic [31:0] cnt [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt[i] <= '0;
      else if (xfer && gnt[i])   cnt[i] <= cnt[i] + 32'd1;
    end
    assign xfer_cnt[32*i +: 32] = cnt[i];
  end
`endif

endmodule
